// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit, radix-2 shift-add / restoring divide
module muldiv_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  kill,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Operation context captured at accept
    logic [2:0]           op_r;
    logic [2*W-1:0]       acc;      // mul: {partial product, multiplier}; div: {rem, quot}
    logic [W-1:0]         opnd;     // mul: multiplicand magnitude; div: divisor magnitude
    logic                 neg;      // result needs negation in FIX
    logic                 special;  // bypass result already sits in acc low half
    logic [CNT_WIDTH-1:0] count;
    logic [W-1:0]         q_r;

    logic accept;

    // Request decode: signedness, magnitudes, result sign and bypass cases
    logic           is_div, is_rem, sign_a, sign_b, res_neg;
    logic           div_zero, div_ovf, special_in;
    logic [W-1:0]   mag_a, mag_b, spec_q;

    always_comb begin
        is_div     = op[2];
        is_rem     = op[2] & op[1];
        sign_a     = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM))
                     & a[W-1];
        sign_b     = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) & b[W-1];
        // Negating the most-negative value yields 2^(W-1), which is exact as unsigned.
        mag_a      = sign_a ? (W'(0) - a) : a;
        mag_b      = sign_b ? (W'(0) - b) : b;
        res_neg    = is_rem ? sign_a : (sign_a ^ sign_b);
        div_zero   = is_div & (b == '0);
        div_ovf    = ((op == OP_DIV) || (op == OP_REM))
                     & (a == {1'b1, {(W-1){1'b0}}}) & (b == '1);
        special_in = div_zero | div_ovf;
        if (div_zero) begin
            spec_q = is_rem ? a : '1;
        end else begin
            spec_q = is_rem ? '0 : a;
        end
    end

    // One radix-2 step for each datapath
    logic [W:0]     mul_sum;
    logic [W:0]     trial;
    logic           take;
    logic [2*W-1:0] mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
        // The bit shifted out of rem is treated as an implicit minuend MSB: when set,
        // the shifted remainder is already >= divisor and the low W bits of trial are exact.
        trial    = {1'b0, acc[2*W-2:W-1]} - {1'b0, opnd};
        take     = acc[2*W-1] | ~trial[W];
        div_next = take ? {trial[W-1:0], acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};
    end

    // Sign correction and half/field select for the final result
    logic [2*W-1:0] prod;
    logic [W-1:0]   mul_res, div_raw, div_res, fix_q;

    always_comb begin
        prod    = neg ? ((2*W)'(0) - acc) : acc;
        mul_res = (op_r == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
        div_raw = op_r[1] ? acc[2*W-1:W] : acc[W-1:0];
        div_res = neg ? (W'(0) - div_raw) : div_raw;
        if (special) begin
            fix_q = acc[W-1:0];
        end else begin
            fix_q = op_r[2] ? div_res : mul_res;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; kill overrides everything but reset
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
            end
        endcase
        accept = in_valid & in_ready & ~kill;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = special_in ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (count == '0) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = special_in ? S_FIX : S_RUN;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (kill) begin
            state_next = S_IDLE;
        end
    end

    // Datapath: load on accept, iterate in RUN, register the result in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg     <= 1'b0;
            special <= 1'b0;
            count   <= '0;
            q_r     <= '0;
        end else if (!kill) begin
            if (accept) begin
                op_r    <= op;
                neg     <= res_neg;
                special <= special_in;
                count   <= CNT_WIDTH'(W);
                opnd    <= is_div ? mag_b : mag_a;
                if (special_in) begin
                    acc <= {{W{1'b0}}, spec_q};
                end else begin
                    acc <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
                end
            end else if (state == S_RUN && count != '0) begin
                acc   <= op_r[2] ? div_next : mul_next;
                count <= count - 1'b1;
            end else if (state == S_FIX) begin
                q_r <= fix_q;
            end
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - scoreboard testbench for muldiv_iter
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] q;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int          exp_lat[$];

    muldiv_iter #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
    );

    always #5 clk = ~clk;

    // Behavioural reference using 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = longint'({32'b0, ma});
        ub = longint'({32'b0, mb});
        r  = '0;
        case (mop)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (mb == 0) r = '1;
                else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) r = ma;
                else r = 32'($signed(ma) / $signed(mb));
            end
            3'd5: r = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
            3'd6: begin
                if (mb == 0) r = ma;
                else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) r = '0;
                else r = 32'($signed(ma) % $signed(mb));
            end
            default: r = (mb == 0) ? ma : ma % mb;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] mop, input logic [31:0] ma,
                                     input logic [31:0] mb);
        if (mop[2] && mb == 0) return 1;
        if ((mop == 3'd4 || mop == 3'd6) && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF)
            return 1;
        return 34;
    endfunction

    // Present one request, push its expectation, and let it be accepted at the next edge
    task automatic send(input logic [2:0] sop, input logic [31:0] sa, input logic [31:0] sb,
                        input logic [31:0] eq, input int elat);
        @(negedge clk);
        in_valid = 1'b1;
        op = sop;
        a = sa;
        b = sb;
        exp_q.push_back(eq);
        exp_lat.push_back(elat);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_in_ready op=%0d got=%b want=1", sop, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait for the result, check latency and value against the scoreboard, then hand off
    task automatic collect(input string name);
        int          cyc;
        logic [31:0] eq;
        int          el;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        eq = exp_q.pop_front();
        el = exp_lat.pop_front();
        n_cmp++;
        if (cyc !== el) begin
            n_err++;
            $display("FAIL %s latency got=%0d want=%0d", name, cyc, el);
        end
        n_cmp++;
        if (q !== eq) begin
            n_err++;
            $display("FAIL %s q got=%h want=%h", name, q, eq);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_cmp++;
        if (q !== 32'h0) begin
            n_err++;
            $display("FAIL reset_q got=%h want=0", q);
        end
    endtask

    task automatic test_mul();
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34); collect("mulhu_ff");
        send(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34); collect("mul_ff");
        send(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34); collect("mulh_min");
        send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34); collect("mulhsu_m1");
    endtask

    task automatic test_div();
        send(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34); collect("div_m7_2");
        send(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34); collect("rem_m7_2");
        send(3'd5, 32'd100, 32'd7, 32'd14, 34);              collect("divu_100_7");
        send(3'd7, 32'd100, 32'd7, 32'd2, 34);               collect("remu_100_7");
    endtask

    task automatic test_special();
        send(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);                    collect("div_by0");
        send(3'd7, 32'd5, 32'd0, 32'd5, 1);                            collect("remu_by0");
        send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);    collect("div_ovf");
        send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);            collect("rem_ovf");
    endtask

    task automatic test_random();
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            send(rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb));
            collect("random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq;
        int          cyc;
        send(3'd5, 32'd100, 32'd7, 32'd14, 34);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_wait_done got=%b want=1", out_valid);
        end
        eq = exp_q.pop_front();
        void'(exp_lat.pop_front());
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (q !== eq || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_hold cycle=%0d q=%h valid=%b want q=%h valid=1",
                         i, q, out_valid, eq);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_hold_in_ready cycle=%0d got=%b want=0", i, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = 3'd5;
        a  = 32'd9;
        b  = 32'd3;
        exp_q.push_back(32'd3);
        exp_lat.push_back(34);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || q !== eq) begin
            n_err++;
            $display("FAIL b2b_handoff in_ready=%b q=%h want in_ready=1 q=%h", in_ready, q, eq);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        collect("b2b_divu_9_3");
    endtask

    task automatic test_abort(input bit use_rst);
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'd0;
        a  = 32'd3;
        b  = 32'd4;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else kill = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        kill = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_ready rst=%0d got=%b want=1", use_rst, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_out_valid rst=%0d got=1 want=0", use_rst);
        end
    endtask

    task automatic test_kill_and_reset();
        test_abort(1'b0);
        test_abort(1'b1);
        send(3'd0, 32'd3, 32'd4, 32'd12, 34);
        collect("mul_3x4_after_abort");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_kill_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
